// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clock_set_ctrl: key-driven hh/mm/ss time-setting sequencer. Rev 1.0
// ----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 5_000_000,
  parameter int unsigned TIMEOUT    = 500_000_000,
  parameter int unsigned BLINK_HALF = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic       ena,
  output logic       set,
  output logic [7:0] s_hh,
  output logic [7:0] s_mm,
  output logic [7:0] s_ss,
  output logic [1:0] edit_field,
  output logic       blink
);

  typedef enum logic [2:0] {RUN, SET_HH, SET_MM, SET_SS, LOAD} state_t;

  state_t      state_q;
  logic        mode_q, up_q, dn_q;
  logic [7:0]  e_hh_q, e_mm_q, e_ss_q;
  logic [7:0]  s_hh_q, s_mm_q, s_ss_q;
  logic        ena_q, set_q, blink_q;
  logic [1:0]  field_q;
  logic [31:0] up_cnt_q, dn_cnt_q, idle_q, blink_cnt_q;
  logic        up_rep_q, dn_rep_q;

  logic        mode_ev, up_ev, dn_ev, any_ev, in_edit;
  logic        up_tick, dn_tick, step_up, step_dn, step_both, step_one;
  logic [7:0]  fld_cur, fld_max, fld_d;

  always_comb begin
    mode_ev   = key_mode & ~mode_q;
    up_ev     = key_up & ~up_q;
    dn_ev     = key_down & ~dn_q;
    any_ev    = mode_ev | up_ev | dn_ev;
    in_edit   = (state_q == SET_HH) || (state_q == SET_MM) || (state_q == SET_SS);
    // A nonzero hold count means the key is held and armed for auto-repeat.
    up_tick   = key_up && (up_cnt_q != 32'd0) &&
                (up_rep_q ? (up_cnt_q == REPEAT_PER) : (up_cnt_q == REPEAT_DLY));
    dn_tick   = key_down && (dn_cnt_q != 32'd0) &&
                (dn_rep_q ? (dn_cnt_q == REPEAT_PER) : (dn_cnt_q == REPEAT_DLY));
    step_up   = in_edit && !mode_ev && (up_ev || up_tick);
    step_dn   = in_edit && !mode_ev && (dn_ev || dn_tick);
    step_both = step_up && step_dn;
    step_one  = step_up ^ step_dn;

    fld_cur = e_ss_q;
    fld_max = 8'd59;
    if (state_q == SET_HH) begin
      fld_cur = e_hh_q;
      fld_max = 8'd23;
    end else if (state_q == SET_MM) begin
      fld_cur = e_mm_q;
    end

    if (step_up)
      fld_d = (fld_cur >= fld_max) ? 8'd0 : fld_cur + 8'd1;
    else
      fld_d = (fld_cur == 8'd0) ? fld_max : fld_cur - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mode_q      <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      e_hh_q      <= 8'd0;
      e_mm_q      <= 8'd0;
      e_ss_q      <= 8'd0;
      s_hh_q      <= 8'd0;
      s_mm_q      <= 8'd0;
      s_ss_q      <= 8'd0;
      ena_q       <= 1'b1;
      set_q       <= 1'b0;
      blink_q     <= 1'b0;
      field_q     <= 2'd0;
      up_cnt_q    <= 32'd0;
      dn_cnt_q    <= 32'd0;
      up_rep_q    <= 1'b0;
      dn_rep_q    <= 1'b0;
      idle_q      <= 32'd0;
      blink_cnt_q <= 32'd0;
    end else begin
      mode_q <= key_mode;
      up_q   <= key_up;
      dn_q   <= key_down;
      set_q  <= 1'b0;

      if (!in_edit || mode_ev || step_both || !key_up) begin
        up_cnt_q <= 32'd0;
        up_rep_q <= 1'b0;
      end else if (up_ev) begin
        up_cnt_q <= 32'd1;
        up_rep_q <= 1'b0;
      end else if (up_tick) begin
        up_cnt_q <= 32'd1;
        up_rep_q <= 1'b1;
      end else if (up_cnt_q != 32'd0) begin
        up_cnt_q <= up_cnt_q + 32'd1;
      end

      if (!in_edit || mode_ev || step_both || !key_down) begin
        dn_cnt_q <= 32'd0;
        dn_rep_q <= 1'b0;
      end else if (dn_ev) begin
        dn_cnt_q <= 32'd1;
        dn_rep_q <= 1'b0;
      end else if (dn_tick) begin
        dn_cnt_q <= 32'd1;
        dn_rep_q <= 1'b1;
      end else if (dn_cnt_q != 32'd0) begin
        dn_cnt_q <= dn_cnt_q + 32'd1;
      end

      case (state_q)
        RUN: begin
          ena_q       <= 1'b1;
          field_q     <= 2'd0;
          blink_q     <= 1'b0;
          idle_q      <= 32'd0;
          blink_cnt_q <= 32'd0;
          if (mode_ev) begin
            state_q <= SET_HH;
            ena_q   <= 1'b0;
            field_q <= 2'd1;
            e_hh_q  <= cur_hh;
            e_mm_q  <= cur_mm;
            e_ss_q  <= cur_ss;
          end
        end
        SET_HH, SET_MM, SET_SS: begin
          idle_q <= any_ev ? 32'd0 : idle_q + 32'd1;
          // Restarting blink on a step keeps the new value on screen.
          if (step_one) begin
            blink_cnt_q <= 32'd0;
            blink_q     <= 1'b0;
          end else if (blink_cnt_q == BLINK_HALF - 1) begin
            blink_cnt_q <= 32'd0;
            blink_q     <= ~blink_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
          end

          if (mode_ev) begin
            if (state_q == SET_SS) begin
              state_q <= LOAD;
              set_q   <= 1'b1;
              s_hh_q  <= e_hh_q;
              s_mm_q  <= e_mm_q;
              s_ss_q  <= e_ss_q;
              field_q <= 2'd0;
              blink_q <= 1'b0;
            end else begin
              state_q <= (state_q == SET_HH) ? SET_MM : SET_SS;
              field_q <= field_q + 2'd1;
            end
          end else if (!any_ev && idle_q == TIMEOUT - 1) begin
            state_q <= RUN;
            ena_q   <= 1'b1;
            field_q <= 2'd0;
            blink_q <= 1'b0;
          end else if (step_one) begin
            case (state_q)
              SET_HH:  e_hh_q <= fld_d;
              SET_MM:  e_mm_q <= fld_d;
              default: e_ss_q <= fld_d;
            endcase
          end
        end
        LOAD: begin
          state_q <= RUN;
          ena_q   <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign ena        = ena_q;
  assign set        = set_q;
  assign s_hh       = s_hh_q;
  assign s_mm       = s_mm_q;
  assign s_ss       = s_ss_q;
  assign edit_field = field_q;
  assign blink      = blink_q;

endmodule
`default_nettype wire

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Key-driven time-setting controller for the hh/mm/ss digital clock datapath.
- Sequences the clock's set/ena interface. It captures the live time, lets the user edit hours, minutes and seconds with up/down keys, then issues a one-cycle set pulse carrying the edited values.
- Sits between debounced push-button inputs and the clock counter chain. Also drives display field-select and blink.

Parameters:
- REPEAT_DLY, 25_000_000: cycles a held up/down key must stay high before auto-repeat starts.
- REPEAT_PER, 5_000_000: cycles between auto-repeat steps once repeating.
- TIMEOUT, 500_000_000: cycles without any key edge in an edit state before abandoning the edit.
- BLINK_HALF, 12_500_000: half-period of blink in cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_mode  in  1  debounced level; its rising edge advances the edit field.
- key_up  in  1  debounced level; its rising edge increments the field; auto-repeats when held.
- key_down  in  1  debounced level; its rising edge decrements the field; auto-repeats when held.
- cur_hh  in  8  live hours from the clock, binary 0-23.
- cur_mm  in  8  live minutes, binary 0-59.
- cur_ss  in  8  live seconds, binary 0-59.
- ena  out  1  clock run enable.
- set  out  1  one-cycle load pulse to the clock.
- s_hh  out  8  hours value to load.
- s_mm  out  8  minutes value to load.
- s_ss  out  8  seconds value to load.
- edit_field  out  2  field under edit: 0 none, 1 hh, 2 mm, 3 ss.
- blink  out  1  display blank strobe for the edited field.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=RUN; ena=1; set=0; s_hh=s_mm=s_ss=0; edit_field=0; blink=0.
  - All edge detectors, repeat counters and timers cleared.
  - Reset applied mid-edit discards the edit and emits no set pulse.
- Edge detection: each key is registered once. An "event" is the registered value being 0 while the current input is 1, i.e. same-cycle detection, acted on at that clk edge.
- States: RUN, SET_HH, SET_MM, SET_SS, LOAD.
- RUN:
  - ena=1, edit_field=0, blink=0.
  - A mode event moves to SET_HH and copies cur_hh/mm/ss into the edit registers e_hh/e_mm/e_ss on the same edge.
  - up/down events are ignored in RUN.
- SET_HH / SET_MM / SET_SS:
  - ena=0 (clock frozen); edit_field=1/2/3.
  - A mode event advances HH->MM->SS->LOAD.
- Field arithmetic:
  - An up step adds 1 with wrap: 23->0 for hh, 59->0 for mm/ss.
  - A down step subtracts 1 with wrap: 0->23 for hh, 0->59 for mm/ss.
  - Arithmetic is pure binary, 8-bit; only the active field changes.
- Simultaneous key events:
  - mode together with up/down: mode wins; no step that cycle.
  - up and down together: no step, and both repeat counters are cleared.
- Auto-repeat:
  - While up (or down) stays high after its event, a hold counter counts cycles.
  - An additional step occurs when the counter reaches REPEAT_DLY, then every REPEAT_PER cycles after that.
  - Releasing the key clears the counter.
- Timeout:
  - The idle counter resets on any key event.
  - On reaching TIMEOUT in an edit state, go to RUN with no set pulse; s_* unchanged; ena=1 next cycle.
- LOAD:
  - Lasts exactly one cycle with set=1.
  - s_hh/mm/ss are driven from e_* registered on entry into LOAD, so they are valid in the same cycle as set.
  - ena=0 during LOAD; next state is RUN (ena=1).
  - s_* hold their values until the next LOAD or reset.
- Blink:
  - In edit states, blink toggles every BLINK_HALF cycles, starting at 0 on entry into SET_HH.
  - The blink counter restarts on every up/down step so the edited value is visible immediately.
  - blink=0 in RUN and LOAD.
- Key events in LOAD are ignored, but edge history still updates. A key held across LOAD produces no event in RUN.

Test Plan:
- Params REPEAT_DLY=8, REPEAT_PER=4, TIMEOUT=64, BLINK_HALF=4 for all scenarios.
- Capture and load: cur=13:45:30, mode event -> SET_HH with e=13:45:30. Three mode events more -> exactly one set pulse with s=13:45:30, then ena=1.
- Wrap: in SET_HH with 23, up -> 0. In SET_MM with 0, down -> 59. In SET_SS with 59, up -> 0. Load -> s_hh=0, s_mm=59, s_ss=0.
- Auto-repeat: hold up for 20 cycles in SET_MM from 10 -> steps at the event, at cycle 8, 12 and 16; value 14 on release.
- Timeout: enter SET_HH, change to 5, then no keys for 64 cycles -> RUN, set never asserted, s_* still 0, ena=1.
- Collisions: mode+up in the same cycle in SET_HH=7 -> SET_MM, hh stays 7. up+down in the same cycle -> no change.
- Reset mid-edit: rst during SET_SS -> next cycle RUN, ena=1, set=0, s_*=0, edit_field=0, blink=0.
